// File: rtl/acc_instr_sequencer.sv
// acc_instr_sequencer: buffers accumulator instructions from a valid/ready
// producer, issues them during the accumulator load phase, then runs the
// accumulator in calculate mode for a latched number of cycles and streams
// back each result.
// Optional build macro ACC_SEQ_CLR_EN adds an acc_clr pulse on start and
// restarts the loaded-instruction count for every run.
module acc_instr_sequencer #(
    parameter int DEPTH = 8,
    parameter int CAP   = 32,
    parameter int RUN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_opcode,
    input  logic [3:0]       in_value,
    input  logic             start,
    input  logic [RUN_W-1:0] run_cycles,
    output logic             mode,
    output logic [2:0]       opCode,
    output logic [3:0]       value,
    input  logic             cacheFull,
    input  logic             invalidOp,
    input  logic             overflow,
    input  logic [9:0]       result,
    output logic             res_valid,
    output logic [9:0]       res_data,
    output logic             res_ovf,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       dropped_cnt
`ifdef ACC_SEQ_CLR_EN
    ,
    output logic             acc_clr
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(CAP + 1);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [LW-1:0] CAP_C = LW'(CAP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t state_r, state_next_s;

    logic [6:0]       fifo_mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
    logic [AW:0]      count_r;
    logic [6:0]       head_s;
    logic             full_s, empty_s, xfer_s, drop_s, push_s, pop_s;
    logic             can_issue_s, start_idle_s;
    logic [RUN_W-1:0] run_cnt_r;
    logic [LW-1:0]    loaded_cnt_r;

    logic             mode_next_s;
    logic [2:0]       op_next_s;
    logic [3:0]       val_next_s;

    logic             mode_r, res_valid_r, res_ovf_r, busy_r, done_r, err_r;
    logic [2:0]       opcode_r;
    logic [3:0]       value_r;
    logic [9:0]       res_data_r;
    logic [7:0]       dropped_r;
    logic             issued_r, issued_d_r;

    assign full_s       = (count_r == DEPTH_C);
    assign empty_s      = (count_r == {(AW+1){1'b0}});
    assign in_ready     = ~full_s;
    assign xfer_s       = in_valid & ~full_s;
    // Opcodes x11 are never worth caching: the accumulator would reject them.
    assign drop_s       = xfer_s & (in_opcode[1:0] == 2'b11);
    assign push_s       = xfer_s & ~drop_s;
    assign head_s       = fifo_mem_r[rd_ptr_r];
    assign can_issue_s  = ~empty_s & (loaded_cnt_r < CAP_C);
    assign start_idle_s = (state_r == ST_IDLE) & start;

    // State register with run-length and cache-occupancy bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            run_cnt_r    <= {RUN_W{1'b0}};
            loaded_cnt_r <= {LW{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (start_idle_s) begin
                run_cnt_r <= run_cycles;
            end else if (state_r == ST_CALC) begin
                run_cnt_r <= run_cnt_r - RUN_W'(1);
            end else begin
                run_cnt_r <= run_cnt_r;
            end
`ifdef ACC_SEQ_CLR_EN
            if (start_idle_s) begin
                loaded_cnt_r <= {LW{1'b0}};
            end else if (pop_s) begin
                loaded_cnt_r <= loaded_cnt_r + LW'(1);
            end else begin
                loaded_cnt_r <= loaded_cnt_r;
            end
`else
            if (pop_s) begin
                loaded_cnt_r <= loaded_cnt_r + LW'(1);
            end else begin
                loaded_cnt_r <= loaded_cnt_r;
            end
`endif
        end
    end

    // Next-state decision
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_next_s = ST_LOAD;
                else       state_next_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (can_issue_s)                        state_next_s = ST_LOAD;
                else if (run_cnt_r != {RUN_W{1'b0}})    state_next_s = ST_CALC;
                else                                    state_next_s = ST_DONE;
            end
            ST_CALC: begin
                if (run_cnt_r == RUN_W'(1)) state_next_s = ST_DONE;
                else                        state_next_s = ST_CALC;
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Per-state instruction to present next cycle (NOP unless issuing/calculating)
    always_comb begin
        pop_s       = 1'b0;
        mode_next_s = 1'b0;
        op_next_s   = 3'b111;
        val_next_s  = 4'b0000;
        case (state_r)
            ST_LOAD: begin
                if (can_issue_s) begin
                    pop_s      = 1'b1;
                    op_next_s  = head_s[6:4];
                    val_next_s = head_s[3:0];
                end else begin
                    pop_s      = 1'b0;
                end
            end
            ST_CALC: mode_next_s = 1'b1;
            default: mode_next_s = 1'b0;
        endcase
    end

    // Instruction FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) fifo_mem_r[i] <= 7'd0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= {in_opcode, in_value};
                wr_ptr_r             <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
            else       rd_ptr_r <= rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Accumulator-facing instruction registers and result capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_r      <= 1'b0;
            opcode_r    <= 3'b111;
            value_r     <= 4'b0000;
            issued_r    <= 1'b0;
            issued_d_r  <= 1'b0;
            res_valid_r <= 1'b0;
            res_data_r  <= 10'd0;
            res_ovf_r   <= 1'b0;
        end else begin
            mode_r      <= mode_next_s;
            opcode_r    <= op_next_s;
            value_r     <= val_next_s;
            issued_r    <= pop_s;
            issued_d_r  <= issued_r;
            // The accumulator's result for a calculate cycle is sampled at the end of it.
            res_valid_r <= mode_r;
            if (mode_r) begin
                res_data_r <= result;
                res_ovf_r  <= overflow;
            end else begin
                res_data_r <= res_data_r;
                res_ovf_r  <= res_ovf_r;
            end
        end
    end

    // Status flags: sticky error, drop counter, busy/done, optional clear pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_r     <= 1'b0;
            dropped_r <= 8'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            // Accumulator complaints only count right after a real load issue.
            err_r  <= err_r | (issued_d_r & (invalidOp | cacheFull));
            busy_r <= (state_next_s != ST_IDLE);
            done_r <= (state_r == ST_DONE);
            if (drop_s && (dropped_r != 8'hFF)) dropped_r <= dropped_r + 8'd1;
            else                                dropped_r <= dropped_r;
        end
    end

`ifdef ACC_SEQ_CLR_EN
    logic acc_clr_r;

    // One-cycle accumulator clear when a run is accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) acc_clr_r <= 1'b0;
        else        acc_clr_r <= start_idle_s;
    end

    assign acc_clr = acc_clr_r;
`endif

    assign mode        = mode_r;
    assign opCode      = opcode_r;
    assign value       = value_r;
    assign res_valid   = res_valid_r;
    assign res_data    = res_data_r;
    assign res_ovf     = res_ovf_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;
    assign dropped_cnt = dropped_r;

endmodule

// File: tb/tb_acc_instr_sequencer.sv
// Self-checking bench for acc_instr_sequencer: a small accumulator stub, a
// queue-based reference model checked every cycle, and directed scenarios.
module tb_acc_instr_sequencer;

    localparam int DEPTH = 8;
    localparam int CAP   = 32;
    localparam int RUN_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid, in_ready;
    logic [2:0]       in_opcode;
    logic [3:0]       in_value;
    logic             start;
    logic [RUN_W-1:0] run_cycles;
    logic             mode;
    logic [2:0]       opCode;
    logic [3:0]       value;
    logic             cacheFull, invalidOp, overflow;
    logic [9:0]       result;
    logic             res_valid, res_ovf, busy, done, err;
    logic [9:0]       res_data;
    logic [7:0]       dropped_cnt;
`ifdef ACC_SEQ_CLR_EN
    logic             acc_clr;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    acc_instr_sequencer #(.DEPTH(DEPTH), .CAP(CAP), .RUN_W(RUN_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_value(in_value),
        .start(start), .run_cycles(run_cycles),
        .mode(mode), .opCode(opCode), .value(value),
        .cacheFull(cacheFull), .invalidOp(invalidOp),
        .overflow(overflow), .result(result),
        .res_valid(res_valid), .res_data(res_data), .res_ovf(res_ovf),
        .busy(busy), .done(done), .err(err), .dropped_cnt(dropped_cnt)
`ifdef ACC_SEQ_CLR_EN
        , .acc_clr(acc_clr)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Accumulator stub: caches loaded values, adds them in turn when calculating.
    logic [9:0]  stub_acc;
    logic [3:0]  stub_cache [0:63];
    int          stub_n, stub_pc;
    logic [10:0] stub_sum;

    always_comb begin
        stub_sum = {1'b0, stub_acc};
        if (stub_n > 0) stub_sum = {1'b0, stub_acc} + {7'd0, stub_cache[stub_pc]};
        result   = mode ? stub_sum[9:0] : stub_acc;
        overflow = mode & stub_sum[10];
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            stub_acc <= 10'd0;
            stub_n   <= 0;
            stub_pc  <= 0;
        end else if (mode) begin
            stub_acc <= result;
            stub_pc  <= (stub_pc + 1 >= stub_n) ? 0 : stub_pc + 1;
        end else if (opCode != 3'b111 && stub_n < 64) begin
            stub_cache[stub_n] <= value;
            stub_n             <= stub_n + 1;
        end
    end

    // Reference model state and observation counters
    logic [6:0]  mdl_q [$];
    int          mdl_drop, mdl_loaded;
    logic        mdl_err, mdl_prev_issue, mdl_prev_mode1, mdl_prev_ovf;
    logic [9:0]  mdl_prev_res;
    logic [10:0] res_log [$];
    int          cyc = 0, issue_cnt = 0, calc_cnt = 0, resv_cnt = 0, done_cnt = 0;
    int          last_issue_cyc = 0, last_done_cyc = 0;
    logic        done_res_ok = 1'b0;

    // Compare process: record handshakes at the edge, check outputs mid-cycle.
    initial begin
        logic       pv, issue_now;
        logic [6:0] pdat, exp_i;
        forever begin
            @(posedge clk);
            pv   = reset && in_valid && in_ready;
            pdat = {in_opcode, in_value};
            @(negedge clk);
            cyc++;
            if (!reset) begin
                mdl_q.delete();
                mdl_drop = 0; mdl_loaded = 0; mdl_err = 1'b0;
                mdl_prev_issue = 1'b0; mdl_prev_mode1 = 1'b0;
                mdl_prev_res = 10'd0; mdl_prev_ovf = 1'b0;
            end else begin
                if (pv) begin
                    if (pdat[5:4] == 2'b11) mdl_drop = (mdl_drop < 255) ? mdl_drop + 1 : 255;
                    else                    mdl_q.push_back(pdat);
                end
                issue_now = (mode == 1'b0) && (opCode != 3'b111);
                if (issue_now) begin
                    if (mdl_q.size() == 0) begin
                        chk("issue_without_entry", 32'd1, 32'd0);
                    end else begin
                        exp_i = mdl_q.pop_front();
                        chk("issue_order", {25'd0, opCode, value}, {25'd0, exp_i});
                    end
                    mdl_loaded++;
                    chk("issue_within_cap", (mdl_loaded <= CAP), 32'd1);
                    issue_cnt++;
                    last_issue_cyc = cyc;
                end
                chk("in_ready", in_ready, (mdl_q.size() < DEPTH));
                chk("dropped_cnt", dropped_cnt, mdl_drop);
                chk("err", err, mdl_err);
                chk("res_valid", res_valid, mdl_prev_mode1);
                if (res_valid) begin
                    chk("res_data", res_data, mdl_prev_res);
                    chk("res_ovf", res_ovf, mdl_prev_ovf);
                    resv_cnt++;
                    res_log.push_back({res_ovf, res_data});
                end
                if (mode) calc_cnt++;
                if (done) begin
                    done_cnt++;
                    last_done_cyc = cyc;
                    done_res_ok   = res_valid;
                end
                mdl_err        = mdl_err | (mdl_prev_issue & (invalidOp | cacheFull));
                mdl_prev_issue = issue_now;
                mdl_prev_mode1 = mode;
                mdl_prev_res   = result;
                mdl_prev_ovf   = overflow;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic push(input logic [2:0] op, input logic [3:0] val);
        logic rdy;
        int   n;
        in_valid = 1'b1; in_opcode = op; in_value = val;
        n = 0;
        rdy = 1'b0;
        while (!rdy && n < 200) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdy) chk("push_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start(input int n);
        run_cycles = RUN_W'(n);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_cnt <= d0 && n < 300) begin
            tick(1);
            n++;
        end
        if (done_cnt <= d0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_issue(input int i0);
        int n = 0;
        while (issue_cnt <= i0 && n < 100) begin
            tick(1);
            n++;
        end
        if (issue_cnt <= i0) chk("issue_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0, c0, r0, d0, rl0;
        logic [10:0] rv;
        reset = 1'b0; in_valid = 1'b0; in_opcode = 3'd0; in_value = 4'd0;
        start = 1'b0; run_cycles = '0; cacheFull = 1'b0; invalidOp = 1'b0;
        tick(3);
        chk("rst_mode", mode, 32'd0);
        chk("rst_opCode", opCode, 32'd7);
        chk("rst_value", value, 32'd0);
        chk("rst_res_valid", res_valid, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_done", done, 32'd0);
        chk("rst_err", err, 32'd0);
        chk("rst_dropped", dropped_cnt, 32'd0);
        chk("rst_in_ready", in_ready, 32'd1);
        reset = 1'b1;
        tick(2);

        // invalidOp after a NOP must be ignored.
        invalidOp = 1'b1; tick(1); invalidOp = 1'b0; tick(3);
        chk("nop_invalid_ignored", err, 32'd0);

        // Two loads, two calculate cycles; a stray start mid-run is ignored.
        i0 = issue_cnt; c0 = calc_cnt; r0 = resv_cnt; d0 = done_cnt; rl0 = res_log.size();
        push(3'b000, 4'd5);
        push(3'b000, 4'd3);
        pulse_start(2);
        wait_issue(i0);
        pulse_start(5);
        wait_done(d0);
        chk("s1_issues", issue_cnt - i0, 32'd2);
        chk("s1_calc_cycles", calc_cnt - c0, 32'd2);
        chk("s1_results", resv_cnt - r0, 32'd2);
        rv = res_log[rl0];
        chk("s1_res0_data", rv[9:0], 32'd5);
        chk("s1_res0_ovf", rv[10], 32'd0);
        rv = res_log[rl0 + 1];
        chk("s1_res1_data", rv[9:0], 32'd8);
        chk("s1_res1_ovf", rv[10], 32'd0);
        chk("s1_done_with_last_res", done_res_ok, 32'd1);
        tick(10);
        chk("s1_single_done", done_cnt - d0, 32'd1);
        chk("s1_idle", busy, 32'd0);

        // Reserved opcodes are consumed but dropped.
        i0 = issue_cnt; r0 = resv_cnt; d0 = done_cnt;
        push(3'b011, 4'd1);
        push(3'b111, 4'd2);
        push(3'b000, 4'd4);
        tick(1);
        chk("s2_dropped", dropped_cnt, 32'd2);
        pulse_start(1);
        wait_done(d0);
        chk("s2_issues", issue_cnt - i0, 32'd1);
        chk("s2_results", resv_cnt - r0, 32'd1);
        chk("s2_err", err, 32'd0);

        // Fill the FIFO, then load until the cache capacity is reached.
        do_reset();
        i0 = issue_cnt; c0 = calc_cnt; d0 = done_cnt;
        fork
            begin
                for (int k = 0; k < 34; k++) push(3'b000, 4'd1);
            end
            begin
                tick(12);
                chk("s3_full_backpressure", in_ready, 32'd0);
                pulse_start(1);
            end
        join
        wait_done(d0);
        tick(2);
        chk("s3_issues", issue_cnt - i0, 32'd32);
        chk("s3_calc_cycles", calc_cnt - c0, 32'd1);
        chk("s3_left_in_fifo", mdl_q.size(), 32'd2);
        chk("s3_in_ready", in_ready, 32'd1);
        chk("s3_err", err, 32'd0);

        // Zero run cycles: one issue, no calculate, done right after load.
        do_reset();
        i0 = issue_cnt; c0 = calc_cnt; r0 = resv_cnt; d0 = done_cnt;
        push(3'b001, 4'd1);
        pulse_start(0);
        wait_done(d0);
        chk("s4_issues", issue_cnt - i0, 32'd1);
        chk("s4_calc_cycles", calc_cnt - c0, 32'd0);
        chk("s4_results", resv_cnt - r0, 32'd0);
        chk("s4_done_latency", last_done_cyc - last_issue_cyc, 32'd2);

        // Reset in the middle of loading.
        do_reset();
        i0 = issue_cnt; d0 = done_cnt;
        push(3'b000, 4'd1);
        push(3'b000, 4'd2);
        push(3'b000, 4'd3);
        pulse_start(1);
        wait_issue(i0);
        reset = 1'b0;
        #1;
        chk("s5_async_mode", mode, 32'd0);
        chk("s5_async_opCode", opCode, 32'd7);
        chk("s5_async_value", value, 32'd0);
        chk("s5_async_busy", busy, 32'd0);
        chk("s5_async_in_ready", in_ready, 32'd1);
        tick(2);
        reset = 1'b1;
        tick(5);
        chk("s5_no_done", done_cnt - d0, 32'd0);
        chk("s5_in_ready", in_ready, 32'd1);
        i0 = issue_cnt; d0 = done_cnt;
        pulse_start(0);
        wait_done(d0);
        chk("s5_fifo_was_flushed", issue_cnt - i0, 32'd0);

        // invalidOp after a real issue sets a sticky error.
        do_reset();
        i0 = issue_cnt; d0 = done_cnt;
        push(3'b000, 4'd2);
        push(3'b000, 4'd1);
        pulse_start(1);
        wait_issue(i0);
        invalidOp = 1'b1; tick(1); invalidOp = 1'b0;
        wait_done(d0);
        tick(1);
        chk("s6_err_set", err, 32'd1);
        d0 = done_cnt;
        push(3'b000, 4'd1);
        pulse_start(1);
        wait_done(d0);
        tick(2);
        chk("s6_err_sticky", err, 32'd1);
        do_reset();
        chk("s6_err_cleared", err, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/acc_instr_sequencer.md
Name: acc_instr_sequencer

Overview:
Instruction source for the 10-bit mode/opCode/value accumulator. It sits upstream of the accumulator, which has no valid strobe and loads on every mode=0 clock. Instructions are buffered from a valid/ready producer and sequenced into the accumulator's load phase. The block then switches the accumulator to calculate mode for a programmed number of cycles and returns each result on a streaming result port.

Parameters:
DEPTH, 8, input FIFO entries (power of 2)
CAP, 32, accumulator instruction-cache capacity
RUN_W, 8, width of run_cycles and run counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  producer has an instruction
in_ready  out  1  FIFO can accept
in_opcode  in  3  instruction opcode
in_value  in  4  instruction operand
start  in  1  one-cycle pulse; honoured only in IDLE
run_cycles  in  RUN_W  calculate cycles; latched on start
mode  out  1  to accumulator (0 = load, 1 = calculate)
opCode  out  3  to accumulator
value  out  4  to accumulator
cacheFull  in  1  from accumulator
invalidOp  in  1  from accumulator
overflow  in  1  from accumulator
result  in  10  from accumulator
res_valid  out  1  res_data/res_ovf valid this cycle
res_data  out  10  captured accumulator result
res_ovf  out  1  captured overflow
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of run
err  out  1  sticky protocol error
dropped_cnt  out  8  saturating count of rejected inputs

Behaviour:
- Reset (reset=0, async) values:
  - mode=0, opCode=3'b111, value=0.
  - res_valid=0, res_data=0, res_ovf=0, busy=0, done=0, err=0, dropped_cnt=0.
  - in_ready=1. FIFO empty, loaded_cnt=0, state=IDLE.
- All outputs are registered except in_ready (= FIFO not full).
- Input handshake:
  - A transfer occurs when in_valid and in_ready are both 1.
  - Opcode 3'b011 or 3'b111 is consumed but not stored; dropped_cnt increments, saturating at 255.
  - Push is allowed in any state. Push and pop may occur in the same cycle.
- NOP: whenever no instruction is issued, drive mode=0, opCode=3'b111, value=0. The accumulator rejects 111 without loading.
- State machine: IDLE -> LOAD -> CALC -> DONE -> IDLE.
- IDLE:
  - Drive NOP.
  - On start: latch run_cycles and go to LOAD.
- LOAD:
  - Each cycle with FIFO non-empty and loaded_cnt<CAP: pop the head, drive mode=0 with the head's opCode/value, and increment loaded_cnt.
  - Exit when the FIFO is empty or loaded_cnt==CAP. Go to CALC if the latched run count is >0, else DONE.
  - An empty FIFO at start gives zero issues.
- CALC:
  - Drive mode=1 for exactly the latched run count, then go to DONE.
  - res_valid pulses 1 the cycle after each mode=1 cycle, capturing result and overflow. Results stream one per cycle, N pulses total.
- DONE:
  - Drive NOP and pulse done for 1 cycle, then return to IDLE.
  - The last res_valid coincides with the done cycle.
- loaded_cnt persists across runs, because the accumulator keeps its cache. It is cleared only by reset (or by the optional feature).
- err is set, sticky until reset, when:
  - invalidOp=1 in the cycle after a real (non-NOP) load issue, or
  - cacheFull=1 in the cycle after a real load issue.
  invalidOp following a NOP is ignored.
- start outside IDLE is ignored.
- Reset mid-run aborts immediately. FIFO contents are lost and no done pulse is generated.

Optional Feature:
ACC_SEQ_CLR_EN:
- Defined: adds output acc_clr (1 bit, active-high, reset value 0). On start in IDLE, acc_clr is driven 1 for one cycle, loaded_cnt is cleared, and LOAD begins the following cycle. Each run therefore sees an empty accumulator cache.
- Undefined: no acc_clr port; loaded_cnt accumulates across runs as described above.

Test Plan:
- Push (000,5) and (000,3), then start with run_cycles=2 -> two mode=0 issues 000/5 then 000/3; two mode=1 cycles; res_data=5 then 8, res_ovf=0; done pulses with the 2nd res_valid.
- Push (011,1), (111,2), (000,4) -> dropped_cnt=2; only 000/4 is issued; err=0.
- Push 34 x (000,1) continuously with DEPTH=8 and start early -> in_ready drops when FIFO full; exactly 32 issues, then CALC; 2 entries remain in FIFO; err=0.
- Push (001,1), start with run_cycles=0 -> one issue, no mode=1 cycle, no res_valid, done one cycle after LOAD exit.
- Drive reset=0 mid-LOAD with 3 entries queued -> outputs return to reset values asynchronously; after release in_ready=1, FIFO empty, no done.
- Testbench model forces invalidOp=1 after a real issue -> err=1 and stays 1 through a later run until reset.
